// File: rtl/btn_pkg.sv
// Shared constants for the ULX3S push-button conditioning path.
package btn_pkg;

  localparam int N_BTN_ULX3S   = 7;
  localparam int CLK_HZ        = 25000000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int LONG_1S       = CLK_HZ;

  // Bit positions of the board buttons within btn_raw and its derived vectors.
  typedef enum int unsigned {
    BTN_PWR   = 0,
    BTN_FIRE1 = 1,
    BTN_FIRE2 = 2,
    BTN_UP    = 3,
    BTN_DOWN  = 4,
    BTN_LEFT  = 5,
    BTN_RIGHT = 6
  } btn_idx_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// Raw button pads in, conditioned levels and event pulses out.
interface btn_conditioner_if #(
  parameter int N_BTN = 7
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic             any_press;

  // Board side: drives the pads, consumes the cleaned signals.
  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, btn_long, any_press
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, btn_long, any_press
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, hold counter and
// registered press/release/long-press pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic press_next
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HCNT_PRE  = HW'(LONG_CYCLES - 1);

  logic          sync1_q,   sync1_d;
  logic          sync2_q,   sync2_d;
  logic          level_q,   level_d;
  logic          press_q,   press_d;
  logic          release_q, release_d;
  logic          long_q,    long_d;
  logic [DW-1:0] dcnt_q,    dcnt_d;
  logic [HW-1:0] hcnt_q,    hcnt_d;
  logic          accept;

  // Next-state: sync shift, debounce acceptance, hold counting and pulses.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    accept    = (sync2_q != level_q) && (dcnt_q == DCNT_LAST);
    dcnt_d    = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    hcnt_d    = '0;

    if (accept) begin
      level_d   = sync2_q;
      press_d   = sync2_q;
      release_d = ~sync2_q;
    end else if (sync2_q != level_q) begin
      dcnt_d = dcnt_q + DW'(1);
    end

    // A flip always restarts the hold count; the long pulse is tied to the
    // single PRE->MAX step so saturation cannot retrigger it.
    if (!accept && level_q) begin
      hcnt_d = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HW'(1);
      long_d = (hcnt_q == HCNT_PRE);
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign press_next  = press_d;

endmodule

// File: rtl/btn_conditioner.sv
// N_BTN independent button channels plus a registered any-press summary.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_ULX3S,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;
  logic [N_BTN-1:0] press_next_w;
  logic             any_press_q, any_press_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk_25mhz   (clk_25mhz),
      .reset       (reset),
      .btn_raw     (bus.btn_raw[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i]),
      .btn_long    (long_w[i]),
      .press_next  (press_next_w[i])
    );
  end

  // OR of the channels' next press pulses, so any_press lines up with btn_press.
  always_comb begin
    any_press_d = |press_next_w;
  end

  // any_press register.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;
  assign bus.any_press   = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed scenarios plus random button activity for btn_conditioner, checked
// against a window-based reference model of the debounce/long-press rules.
module tb_btn_conditioner;

  localparam int N = 7;
  localparam int D = 4;
  localparam int L = 10;

  logic clk_25mhz = 1'b0;
  logic reset     = 1'b1;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .bus       (bus)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with it on each of the last D edges; long fires exactly L edges
  // after the accepted rise if the level is still held.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
  logic         m_any;
  logic [N-1:0] win [D];
  int unsigned  cyc;
  int unsigned  rise_at [N];

  task automatic model_step(input logic rst, input logic [N-1:0] raw);
    logic [N-1:0] acc;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_any = 1'b0;
      for (int j = 0; j < D; j++) win[j] = '0;
    end else begin
      for (int j = D - 1; j > 0; j--) win[j] = win[j-1];
      win[0] = m_s2;
      acc = '1;
      for (int ch = 0; ch < N; ch++)
        for (int j = 0; j < D; j++)
          if (win[j][ch] == m_level[ch]) acc[ch] = 1'b0;
      m_press = acc & ~m_level;
      m_rel   = acc & m_level;
      for (int ch = 0; ch < N; ch++)
        m_long[ch] = m_level[ch] && !acc[ch] && ((cyc - rise_at[ch]) == L);
      for (int ch = 0; ch < N; ch++)
        if (m_press[ch]) rise_at[ch] = cyc;
      m_level = m_level ^ acc;
      m_any   = |m_press;
      m_s2    = m_s1;
      m_s1    = raw;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] b2v(input logic b);
    return {{(N-1){1'b0}}, b};
  endfunction

  // One clock: drive on the falling edge, step the model on the rising edge,
  // sample 1 time unit later.
  task automatic tick(input logic rst, input logic [N-1:0] raw);
    @(negedge clk_25mhz);
    reset       = rst;
    bus.btn_raw = raw;
    @(posedge clk_25mhz);
    model_step(rst, raw);
    #1;
    chk("model_level",   bus.btn_level,        m_level);
    chk("model_press",   bus.btn_press,        m_press);
    chk("model_release", bus.btn_release,      m_rel);
    chk("model_long",    bus.btn_long,         m_long);
    chk("model_any",     b2v(bus.any_press),   b2v(m_any));
  endtask

  initial begin
    int           pr;
    int           lg;
    int           nlong;
    logic [N-1:0] r;
    logic         b;

    cyc = 0;
    for (int ch = 0; ch < N; ch++) rise_at[ch] = 0;
    bus.btn_raw = '0;

    // Reset with all buttons held, then held through reset release.
    repeat (3) begin
      tick(1'b1, 7'h7F);
      chk("rst_level", bus.btn_level, 7'h00);
      chk("rst_press", bus.btn_press, 7'h00);
      chk("rst_long",  bus.btn_long,  7'h00);
      chk("rst_any",   b2v(bus.any_press), 7'h00);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 7'h7F);
      chk("post_rst_press", bus.btn_press, (i == 6) ? 7'h7F : 7'h00);
      chk("post_rst_any",   b2v(bus.any_press), b2v(i == 6));
    end
    for (int i = 1; i <= 11; i++) begin
      tick(1'b0, 7'h7F);
      chk("long_all",  bus.btn_long,  (i == 10) ? 7'h7F : 7'h00);
      chk("hold_nopr", bus.btn_press, 7'h00);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 7'h00);
      chk("rel_all",       bus.btn_release, (i == 6) ? 7'h7F : 7'h00);
      chk("rel_all_level", bus.btn_level,   (i == 6) ? 7'h00 : 7'h7F);
    end

    // Clean press on button 1.
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 7'h02);
      chk("clean_level", bus.btn_level, (i == 6) ? 7'h02 : 7'h00);
      chk("clean_press", bus.btn_press, (i == 6) ? 7'h02 : 7'h00);
    end
    repeat (14) tick(1'b0, 7'h02);

    // Buttons 3 and 5 rise while button 1 falls.
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 7'h28);
      chk("simul_press",   bus.btn_press,   (i == 6) ? 7'h28 : 7'h00);
      chk("simul_release", bus.btn_release, (i == 6) ? 7'h02 : 7'h00);
      chk("simul_any",     b2v(bus.any_press), b2v(i == 6));
    end
    repeat (20) tick(1'b0, 7'h00);

    // Bounce on button 0: high 3, low 1, high 3, then low.
    for (int i = 0; i < 16; i++) begin
      b = (i < 3) || (i >= 4 && i < 7);
      tick(1'b0, b2v(b));
      chk("bounce_level", bus.btn_level,   7'h00);
      chk("bounce_press", bus.btn_press,   7'h00);
      chk("bounce_rel",   bus.btn_release, 7'h00);
    end

    // Button 2 held 30 cycles: one long pulse, 10 cycles after the press.
    pr = -100; lg = -1; nlong = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 7'h04);
      if (bus.btn_press[2]) pr = i;
      if (bus.btn_long[2]) begin nlong++; lg = i; end
    end
    chk("long_count", N'(nlong), N'(1));
    chk("long_delay", N'(lg - pr), N'(L));
    repeat (12) tick(1'b0, 7'h00);

    // Button 2 pressed but released well before the long threshold.
    nlong = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 7'h04);
      if (bus.btn_long[2]) nlong++;
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 7'h00);
      if (bus.btn_long[2]) nlong++;
    end
    chk("short_nolong", N'(nlong), N'(0));

    // Reset while button 4 is part-way through its debounce window.
    repeat (4) tick(1'b0, 7'h10);
    repeat (2) begin
      tick(1'b1, 7'h10);
      chk("middeb_press", bus.btn_press, 7'h00);
      chk("middeb_level", bus.btn_level, 7'h00);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 7'h10);
      chk("middeb_restart", bus.btn_press, (i == 6) ? 7'h10 : 7'h00);
    end
    repeat (10) tick(1'b0, 7'h00);

    // Random activity with occasional resets.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
      tick($urandom_range(0, 199) == 0, r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
